// File: rtl/exe_stage.sv
// Execute stage: latches the decoded bundle, computes the ALU result, issues the
// data-SRAM request for ld.w/st.w and hands a compact bundle to the memory stage.
module exe_stage #(
    parameter int TO_EX_W  = 150,
    parameter int TO_MEM_W = 71
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ID_to_EX_valid,
    output logic                EX_allow_in,
    input  logic [TO_EX_W-1:0]  to_EX_data,
    input  logic                MEM_allow_in,
    output logic                EX_to_MEM_valid,
    output logic [TO_MEM_W-1:0] to_MEM_data,
    output logic                data_sram_req,
    output logic                data_sram_wr,
    output logic [31:0]         data_sram_addr,
    output logic [3:0]          data_sram_wstrb,
    output logic [31:0]         data_sram_wdata,
    input  logic                data_sram_addr_ok
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_ACCEPTED = 1'b1
    } req_state_t;

    logic               r_ex_valid;
    logic [TO_EX_W-1:0] r_ex_data;
    req_state_t         r_state;

    logic [31:0] w_pc, w_rj_value, w_rkd_value, w_imm;
    logic [11:0] w_alu_op;
    logic        w_src1_is_pc, w_src2_is_imm, w_mem_we, w_res_from_mem, w_gr_we;
    logic [4:0]  w_dest;

    assign w_pc           = r_ex_data[149:118];
    assign w_rj_value     = r_ex_data[117:86];
    assign w_rkd_value    = r_ex_data[85:54];
    assign w_imm          = r_ex_data[53:22];
    assign w_alu_op       = r_ex_data[21:10];
    assign w_src1_is_pc   = r_ex_data[9];
    assign w_src2_is_imm  = r_ex_data[8];
    assign w_mem_we       = r_ex_data[7];
    assign w_res_from_mem = r_ex_data[6];
    assign w_dest         = r_ex_data[5:1];
    assign w_gr_we        = r_ex_data[0];

    logic        w_mem_op, w_sent, w_ready_go, w_advance;
    logic [31:0] w_src1, w_src2, w_alu_result;

    assign w_mem_op   = w_mem_we | w_res_from_mem;
    assign w_sent     = (r_state == S_ACCEPTED);
    // An accepted address in this very cycle lets the instruction leave without waiting.
    assign w_ready_go = ~w_mem_op | w_sent | (data_sram_req & data_sram_addr_ok);
    assign w_advance  = r_ex_valid & w_ready_go & MEM_allow_in;

    assign EX_allow_in     = ~r_ex_valid | (w_ready_go & MEM_allow_in);
    assign EX_to_MEM_valid = r_ex_valid & w_ready_go;

    assign w_src1 = w_src1_is_pc  ? w_pc  : w_rj_value;
    assign w_src2 = w_src2_is_imm ? w_imm : w_rkd_value;

    logic [31:0] w_sum, w_diff, w_sll, w_srl, w_sra;
    logic        w_slt, w_sltu;
    logic [4:0]  w_shamt;

    assign w_shamt = w_src2[4:0];
    assign w_sum   = w_src1 + w_src2;
    assign w_diff  = w_src1 - w_src2;
    assign w_slt   = $signed(w_src1) < $signed(w_src2);
    assign w_sltu  = w_src1 < w_src2;
    assign w_sll   = w_src1 << w_shamt;
    assign w_srl   = w_src1 >> w_shamt;
    assign w_sra   = $unsigned($signed(w_src1) >>> w_shamt);

    // alu_op is one-hot, so OR-ing masked terms yields 0 when no bit is set.
    always_comb begin
        w_alu_result = '0;
        w_alu_result = w_alu_result
                     | ({32{w_alu_op[0]}}  & w_sum)
                     | ({32{w_alu_op[1]}}  & w_diff)
                     | ({32{w_alu_op[2]}}  & {31'b0, w_slt})
                     | ({32{w_alu_op[3]}}  & {31'b0, w_sltu})
                     | ({32{w_alu_op[4]}}  & (w_src1 & w_src2))
                     | ({32{w_alu_op[5]}}  & ~(w_src1 | w_src2))
                     | ({32{w_alu_op[6]}}  & (w_src1 | w_src2))
                     | ({32{w_alu_op[7]}}  & (w_src1 ^ w_src2))
                     | ({32{w_alu_op[8]}}  & w_sll)
                     | ({32{w_alu_op[9]}}  & w_srl)
                     | ({32{w_alu_op[10]}} & w_sra)
                     | ({32{w_alu_op[11]}} & w_src2);
    end

    assign data_sram_req   = r_ex_valid & w_mem_op & ~w_sent;
    assign data_sram_wr    = w_mem_we;
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wstrb = w_mem_we ? 4'hf : 4'h0;
    assign data_sram_wdata = w_rkd_value;

    assign to_MEM_data = {w_pc, w_alu_result, w_res_from_mem, w_dest, w_gr_we};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
            r_ex_data  <= '0;
        end else if (EX_allow_in) begin
            r_ex_valid <= ID_to_EX_valid;
            if (ID_to_EX_valid)
                r_ex_data <= to_EX_data;
        end
    end

    // Remembers an accepted address while the memory stage is blocked, so no re-request.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else if (w_advance)
            r_state <= S_IDLE;
        else if (data_sram_req & data_sram_addr_ok)
            r_state <= S_ACCEPTED;
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, store stall, load held by memory stage,
// back-to-back flow and reset during a pending request.
module tb_exe_stage;

    logic         clk;
    logic         reset;
    logic         ID_to_EX_valid;
    logic         EX_allow_in;
    logic [149:0] to_EX_data;
    logic         MEM_allow_in;
    logic         EX_to_MEM_valid;
    logic [70:0]  to_MEM_data;
    logic         data_sram_req;
    logic         data_sram_wr;
    logic [31:0]  data_sram_addr;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_wdata;
    logic         data_sram_addr_ok;

    int checks = 0;
    int errors = 0;

    exe_stage #(.TO_EX_W(150), .TO_MEM_W(71)) dut (
        .clk               (clk),
        .reset             (reset),
        .ID_to_EX_valid    (ID_to_EX_valid),
        .EX_allow_in       (EX_allow_in),
        .to_EX_data        (to_EX_data),
        .MEM_allow_in      (MEM_allow_in),
        .EX_to_MEM_valid   (EX_to_MEM_valid),
        .to_MEM_data       (to_MEM_data),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [149:0] mk(input logic [31:0] pc, input logic [31:0] rj,
                                        input logic [31:0] rkd, input logic [31:0] imm,
                                        input logic [11:0] op, input logic s1pc,
                                        input logic s2imm, input logic we, input logic rfm,
                                        input logic [4:0] dest, input logic grwe);
        return {pc, rj, rkd, imm, op, s1pc, s2imm, we, rfm, dest, grwe};
    endfunction

    task automatic test_reset();
        reset = 1'b1; ID_to_EX_valid = 1'b0; to_EX_data = '0;
        MEM_allow_in = 1'b1; data_sram_addr_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (EX_allow_in !== 1'b1) begin errors++; $display("FAIL reset_allow_in got=%b exp=1", EX_allow_in); end
        checks++;
        if (EX_to_MEM_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", EX_to_MEM_valid); end
        checks++;
        if (data_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", data_sram_req); end
        checks++;
        if (to_MEM_data !== 71'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", to_MEM_data); end
        $display("reset: allow_in=%b valid=%b req=%b", EX_allow_in, EX_to_MEM_valid, data_sram_req);
    endtask

    task automatic test_alu();
        logic [149:0] vec [14];
        logic [31:0]  exp [14];
        logic [31:0]  pcv;
        vec[0]  = mk(0, 32'h7fffffff, 32'h1, 0, 12'h001, 0, 0, 0, 0, 5'd1, 1); exp[0]  = 32'h80000000;
        vec[1]  = mk(0, 32'h5, 32'h7, 0, 12'h002, 0, 0, 0, 0, 5'd1, 1);        exp[1]  = 32'hfffffffe;
        vec[2]  = mk(0, 32'hffffffff, 32'h1, 0, 12'h004, 0, 0, 0, 0, 5'd1, 1); exp[2]  = 32'h1;
        vec[3]  = mk(0, 32'hffffffff, 32'h1, 0, 12'h008, 0, 0, 0, 0, 5'd1, 1); exp[3]  = 32'h0;
        vec[4]  = mk(0, 32'hf0f0, 32'hff00, 0, 12'h010, 0, 0, 0, 0, 5'd1, 1);  exp[4]  = 32'hf000;
        vec[5]  = mk(0, 32'h0, 32'h0, 0, 12'h020, 0, 0, 0, 0, 5'd1, 1);        exp[5]  = 32'hffffffff;
        vec[6]  = mk(0, 32'h0f, 32'hf0, 0, 12'h040, 0, 0, 0, 0, 5'd1, 1);      exp[6]  = 32'hff;
        vec[7]  = mk(0, 32'hff, 32'h0f, 0, 12'h080, 0, 0, 0, 0, 5'd1, 1);      exp[7]  = 32'hf0;
        vec[8]  = mk(0, 32'h1, 32'h0, 32'd31, 12'h100, 0, 1, 0, 0, 5'd1, 1);   exp[8]  = 32'h80000000;
        vec[9]  = mk(0, 32'h80000000, 32'h24, 0, 12'h200, 0, 0, 0, 0, 5'd1, 1); exp[9] = 32'h08000000;
        vec[10] = mk(0, 32'h80000000, 32'h0, 32'd4, 12'h400, 0, 1, 0, 0, 5'd1, 1); exp[10] = 32'hf8000000;
        vec[11] = mk(0, 32'hffff, 32'h0, 32'h12345000, 12'h800, 0, 1, 0, 0, 5'd1, 1); exp[11] = 32'h12345000;
        vec[12] = mk(0, 32'h99, 32'h0, 32'd4, 12'h001, 1, 1, 0, 0, 5'd1, 1);   exp[12] = 32'h1c000034;
        vec[13] = mk(0, 32'h5, 32'h7, 0, 12'h000, 0, 0, 0, 0, 5'd1, 1);        exp[13] = 32'h0;
        for (int i = 0; i < 14; i++) begin
            pcv = 32'h1c000000 + 32'(i * 4);
            vec[i][149:118] = pcv;
            ID_to_EX_valid = 1'b1; to_EX_data = vec[i];
            MEM_allow_in = 1'b1; data_sram_addr_ok = 1'b0;
            @(posedge clk);
            #1 ID_to_EX_valid = 1'b0;
            #1;
            checks++;
            if (EX_to_MEM_valid !== 1'b1) begin errors++; $display("FAIL alu%0d_valid got=%b exp=1", i, EX_to_MEM_valid); end
            checks++;
            if (to_MEM_data[38:7] !== exp[i]) begin errors++; $display("FAIL alu%0d_result got=%h exp=%h", i, to_MEM_data[38:7], exp[i]); end
            checks++;
            if (to_MEM_data[70:39] !== pcv) begin errors++; $display("FAIL alu%0d_pc got=%h exp=%h", i, to_MEM_data[70:39], pcv); end
            checks++;
            if (data_sram_req !== 1'b0) begin errors++; $display("FAIL alu%0d_req got=%b exp=0", i, data_sram_req); end
            $display("alu op=%h pc=%h result=%h", vec[i][21:10], pcv, to_MEM_data[38:7]);
        end
    endtask

    task automatic test_store_stall();
        int req_cycles = 0;
        ID_to_EX_valid = 1'b1; MEM_allow_in = 1'b1; data_sram_addr_ok = 1'b0;
        to_EX_data = mk(32'h100, 32'h1000, 32'hdeadbeef, 32'd8, 12'h001, 0, 1, 1, 0, 5'd0, 0);
        @(posedge clk);
        #1 ID_to_EX_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            data_sram_addr_ok = (c == 3);
            #1;
            if (data_sram_req === 1'b1) req_cycles++;
            checks++;
            if ({data_sram_req, data_sram_wr, data_sram_wstrb} !== 6'b11_1111)
                begin errors++; $display("FAIL st_ctrl c%0d got=%b%b%h exp=11f", c, data_sram_req, data_sram_wr, data_sram_wstrb); end
            checks++;
            if (data_sram_addr !== 32'h1008 || data_sram_wdata !== 32'hdeadbeef)
                begin errors++; $display("FAIL st_addr_data c%0d got=%h/%h exp=1008/deadbeef", c, data_sram_addr, data_sram_wdata); end
            checks++;
            if (EX_allow_in !== (c == 3) || EX_to_MEM_valid !== (c == 3))
                begin errors++; $display("FAIL st_flow c%0d got=%b%b exp=%b%b", c, EX_allow_in, EX_to_MEM_valid, c == 3, c == 3); end
            @(posedge clk);
            #1;
        end
        data_sram_addr_ok = 1'b0;
        #1;
        checks++;
        if (data_sram_req !== 1'b0 || EX_to_MEM_valid !== 1'b0)
            begin errors++; $display("FAIL st_after got=%b%b exp=00", data_sram_req, EX_to_MEM_valid); end
        checks++;
        if (req_cycles != 4) begin errors++; $display("FAIL st_req_cycles got=%0d exp=4", req_cycles); end
        $display("store: addr=1008 req_cycles=%0d", req_cycles);
    endtask

    task automatic test_load_held();
        int req_cycles = 0;
        ID_to_EX_valid = 1'b1; MEM_allow_in = 1'b0; data_sram_addr_ok = 1'b1;
        to_EX_data = mk(32'h200, 32'h2000, 32'h0, 32'h0, 12'h001, 0, 1, 0, 1, 5'd3, 1);
        @(posedge clk);
        #1 ID_to_EX_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            if (data_sram_req === 1'b1) req_cycles++;
            checks++;
            if (data_sram_req !== (c == 0)) begin errors++; $display("FAIL ld_req c%0d got=%b exp=%b", c, data_sram_req, c == 0); end
            checks++;
            if (data_sram_wr !== 1'b0 || data_sram_wstrb !== 4'h0)
                begin errors++; $display("FAIL ld_wr c%0d got=%b/%h exp=0/0", c, data_sram_wr, data_sram_wstrb); end
            checks++;
            if (EX_to_MEM_valid !== 1'b1 || EX_allow_in !== 1'b0)
                begin errors++; $display("FAIL ld_hold c%0d got=%b%b exp=10", c, EX_to_MEM_valid, EX_allow_in); end
            @(posedge clk);
            #1;
        end
        MEM_allow_in = 1'b1;
        #1;
        if (data_sram_req === 1'b1) req_cycles++;
        checks++;
        if (EX_to_MEM_valid !== 1'b1 || EX_allow_in !== 1'b1)
            begin errors++; $display("FAIL ld_go got=%b%b exp=11", EX_to_MEM_valid, EX_allow_in); end
        checks++;
        if (to_MEM_data[70:39] !== 32'h200 || to_MEM_data[6:0] !== 7'h47)
            begin errors++; $display("FAIL ld_bundle got=%h/%h exp=200/47", to_MEM_data[70:39], to_MEM_data[6:0]); end
        checks++;
        if (req_cycles != 1) begin errors++; $display("FAIL ld_req_cycles got=%0d exp=1", req_cycles); end
        @(posedge clk);
        #1 data_sram_addr_ok = 1'b0;
        #1;
        checks++;
        if (EX_to_MEM_valid !== 1'b0) begin errors++; $display("FAIL ld_drained got=%b exp=0", EX_to_MEM_valid); end
        $display("load: pc=200 req_cycles=%0d", req_cycles);
    endtask

    task automatic test_back_to_back();
        logic [149:0] prog [4];
        logic [31:0]  exp_pc [4];
        logic [31:0]  got [$];
        int idx = 0;
        int req_cycles = 0;
        prog[0] = mk(32'h300, 32'h1, 32'h2, 0, 12'h001, 0, 0, 0, 0, 5'd4, 1);
        prog[1] = mk(32'h304, 32'h3000, 0, 32'h4, 12'h001, 0, 1, 0, 1, 5'd5, 1);
        prog[2] = mk(32'h308, 32'h3000, 0, 32'h8, 12'h001, 0, 1, 0, 1, 5'd6, 1);
        prog[3] = mk(32'h30c, 32'h7, 32'h1, 0, 12'h002, 0, 0, 0, 0, 5'd7, 1);
        exp_pc[0] = 32'h300; exp_pc[1] = 32'h304; exp_pc[2] = 32'h308; exp_pc[3] = 32'h30c;
        for (int c = 0; c < 30; c++) begin
            MEM_allow_in = (c % 3 != 1);
            data_sram_addr_ok = 1'b1;
            ID_to_EX_valid = (idx < 4);
            to_EX_data = prog[(idx < 4) ? idx : 0];
            #1;
            if (data_sram_req === 1'b1) req_cycles++;
            if (EX_to_MEM_valid === 1'b1 && MEM_allow_in) begin
                got.push_back(to_MEM_data[70:39]);
                $display("b2b: cycle %0d handed pc=%h", c, to_MEM_data[70:39]);
            end
            if (ID_to_EX_valid && EX_allow_in === 1'b1) idx++;
            @(posedge clk);
            #1;
        end
        ID_to_EX_valid = 1'b0; data_sram_addr_ok = 1'b0;
        checks++;
        if (got.size() != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size()) begin errors++; $display("FAIL b2b_pc%0d got=none exp=%h", i, exp_pc[i]); end
            else if (got[i] !== exp_pc[i]) begin errors++; $display("FAIL b2b_pc%0d got=%h exp=%h", i, got[i], exp_pc[i]); end
        end
        checks++;
        if (req_cycles != 2) begin errors++; $display("FAIL b2b_req_cycles got=%0d exp=2", req_cycles); end
    endtask

    task automatic test_reset_mid_request();
        ID_to_EX_valid = 1'b1; MEM_allow_in = 1'b1; data_sram_addr_ok = 1'b0;
        to_EX_data = mk(32'h500, 32'h40, 32'h55, 32'h0, 12'h001, 0, 1, 1, 0, 5'd0, 0);
        @(posedge clk);
        #1 ID_to_EX_valid = 1'b0;
        #1;
        checks++;
        if (data_sram_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre_req got=%b exp=1", data_sram_req); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (data_sram_req !== 1'b0 || EX_to_MEM_valid !== 1'b0 || EX_allow_in !== 1'b1)
            begin errors++; $display("FAIL rstmid got=%b%b%b exp=001", data_sram_req, EX_to_MEM_valid, EX_allow_in); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (data_sram_req !== 1'b0 || EX_to_MEM_valid !== 1'b0)
            begin errors++; $display("FAIL rstmid_after got=%b%b exp=00", data_sram_req, EX_to_MEM_valid); end
        $display("reset mid-request: req=%b valid=%b", data_sram_req, EX_to_MEM_valid);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_stall();
        test_load_held();
        test_back_to_back();
        test_reset_mid_request();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
